// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared PLIC state encoding and the "no interrupt" ID
//
// Purpose: state encoding for the per-target claim controller and the
//          reserved interrupt ID meaning "nothing claimable".
// Ports:   none (package).

package plic_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } plic_state_e;

  // ID 0 is reserved: a claim read returning it means no interrupt.
  localparam int NO_IRQ_ID = 0;

endpackage

// File: rtl/plic_priority_index.sv
// rtl/plic_priority_index.sv - recursive max-priority/index tree
//
// Purpose: returns the highest priority in prio_i[HI:LO] and the index that
//          carries it. On equal priority the lower slot wins.
// Ports:
//   prio_i  in   [HI:LO] x PRIORITY_BITS  per-slot priority
//   idx_i   in   [HI:LO] x ID_BITS        per-slot index value
//   prio_o  out  PRIORITY_BITS            winning priority
//   idx_o   out  ID_BITS                  index of the winner

module plic_priority_index #(
  parameter int HI            = 15,
  parameter int LO            = 0,
  parameter int PRIORITY_BITS = 3,
  parameter int ID_BITS       = 5
) (
  input  logic [HI:LO][PRIORITY_BITS-1:0] prio_i,
  input  logic [HI:LO][ID_BITS-1:0]       idx_i,
  output logic [PRIORITY_BITS-1:0]        prio_o,
  output logic [ID_BITS-1:0]              idx_o
);

  generate
    if (HI == LO) begin : g_leaf
      assign prio_o = prio_i[LO];
      assign idx_o  = idx_i[LO];
    end else begin : g_node
      localparam int MID = (HI + LO) / 2;

      logic [PRIORITY_BITS-1:0] lo_prio;
      logic [PRIORITY_BITS-1:0] hi_prio;
      logic [ID_BITS-1:0]       lo_idx;
      logic [ID_BITS-1:0]       hi_idx;

      plic_priority_index #(
        .HI            (MID),
        .LO            (LO),
        .PRIORITY_BITS (PRIORITY_BITS),
        .ID_BITS       (ID_BITS)
      ) u_lo (
        .prio_i (prio_i[MID:LO]),
        .idx_i  (idx_i[MID:LO]),
        .prio_o (lo_prio),
        .idx_o  (lo_idx)
      );

      plic_priority_index #(
        .HI            (HI),
        .LO            (MID + 1),
        .PRIORITY_BITS (PRIORITY_BITS),
        .ID_BITS       (ID_BITS)
      ) u_hi (
        .prio_i (prio_i[HI:MID+1]),
        .idx_i  (idx_i[HI:MID+1]),
        .prio_o (hi_prio),
        .idx_o  (hi_idx)
      );

      // Upper half only wins on strictly greater priority: ties go low.
      assign prio_o = (hi_prio > lo_prio) ? hi_prio : lo_prio;
      assign idx_o  = (hi_prio > lo_prio) ? hi_idx  : lo_idx;
    end
  endgenerate

endmodule

// File: rtl/plic_target_claim_ctrl.sv
// rtl/plic_target_claim_ctrl.sv - per-target PLIC claim/complete controller
//
// Purpose: masks source priorities with pending/enable, registers the tree
//          winner, raises irq_o above threshold, serves claim/complete and
//          holds notification off for SETTLE cycles after each claim.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   src_pending_i    gateway pending bits (bit n = ID n+1)
//   src_enable_i     target enable bits
//   src_priority_i   per-source priority
//   threshold_i      target threshold
//   irq_o            interrupt line to hart
//   claim_i          claim-read strobe
//   claim_id_o       claimable ID (0 = none)
//   claim_o          one-hot claim pulse to gateways
//   complete_i       complete-write strobe
//   complete_id_i    ID being completed
//   complete_o       one-hot complete pulse to gateways

module plic_target_claim_ctrl
  import plic_pkg::*;
#(
  parameter int SOURCES       = 16,
  parameter int PRIORITIES    = 7,
  parameter int SETTLE        = 2,
  parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [SOURCES-1:0]                     src_pending_i,
  input  logic [SOURCES-1:0]                     src_enable_i,
  input  logic [SOURCES-1:0][PRIORITY_BITS-1:0]  src_priority_i,
  input  logic [PRIORITY_BITS-1:0]               threshold_i,
  output logic                                   irq_o,
  input  logic                                   claim_i,
  output logic [SOURCES_BITS-1:0]                claim_id_o,
  output logic [SOURCES-1:0]                     claim_o,
  input  logic                                   complete_i,
  input  logic [SOURCES_BITS-1:0]                complete_id_i,
  output logic [SOURCES-1:0]                     complete_o
);

  localparam int CNT_BITS = $clog2(SETTLE + 1);
  localparam logic [SOURCES_BITS-1:0] NO_ID  = SOURCES_BITS'(NO_IRQ_ID);
  localparam logic [SOURCES_BITS-1:0] MAX_ID = SOURCES_BITS'(SOURCES);

  logic [SOURCES-1:0][PRIORITY_BITS-1:0] masked_prio;
  logic [SOURCES-1:0][SOURCES_BITS-1:0]  src_idx;
  logic [PRIORITY_BITS-1:0]              tree_prio;
  logic [SOURCES_BITS-1:0]               tree_id;

  logic [PRIORITY_BITS-1:0] best_prio_q;
  logic [SOURCES_BITS-1:0]  best_id_q;
  plic_state_e              state_q;
  logic [CNT_BITS-1:0]      hold_cnt_q;

  function automatic logic [SOURCES-1:0] id_to_onehot(input logic [SOURCES_BITS-1:0] id);
    return SOURCES'(1) << (id - 1'b1);
  endfunction

  always_comb begin
    masked_prio = '0;
    for (int n = 0; n < SOURCES; n++) begin
      if (src_pending_i[n] && src_enable_i[n]) begin
        masked_prio[n] = src_priority_i[n];
      end
    end
  end

  for (genvar n = 0; n < SOURCES; n++) begin : g_idx
    assign src_idx[n] = SOURCES_BITS'(n + 1);
  end

  plic_priority_index #(
    .HI            (SOURCES - 1),
    .LO            (0),
    .PRIORITY_BITS (PRIORITY_BITS),
    .ID_BITS       (SOURCES_BITS)
  ) u_tree (
    .prio_i (masked_prio),
    .idx_i  (src_idx),
    .prio_o (tree_prio),
    .idx_o  (tree_id)
  );

  // Threshold compare is the only logic between flops and outputs, so a
  // threshold write takes effect on irq_o immediately.
  assign irq_o      = (state_q == ST_RUN) && (best_prio_q > threshold_i);
  assign claim_id_o = irq_o ? best_id_q : NO_ID;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_prio_q <= '0;
      best_id_q   <= NO_ID;
      state_q     <= ST_RUN;
      hold_cnt_q  <= '0;
      claim_o     <= '0;
      complete_o  <= '0;
    end else begin
      best_prio_q <= tree_prio;
      // A zero-priority winner is indistinguishable from no source at all.
      best_id_q   <= (tree_prio == '0) ? NO_ID : tree_id;
      claim_o     <= '0;
      complete_o  <= '0;

      case (state_q)
        ST_RUN: begin
          if (claim_i && (claim_id_o != NO_ID)) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= CNT_BITS'(SETTLE);
            claim_o    <= id_to_onehot(claim_id_o);
          end
        end
        ST_HOLD: begin
          // Hold spans SETTLE cycles so the gateway's pending clear has
          // propagated through best_*_q before irq_o can reassert.
          hold_cnt_q <= hold_cnt_q - 1'b1;
          if (hold_cnt_q == CNT_BITS'(1)) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase

      if (complete_i && (complete_id_i != NO_ID) && (complete_id_i <= MAX_ID)) begin
        complete_o <= id_to_onehot(complete_id_i);
      end
    end
  end

endmodule

// File: tb/tb_plic_target_claim_ctrl.sv
// tb/tb_plic_target_claim_ctrl.sv - self-checking bench for plic_target_claim_ctrl

module tb_plic_target_claim_ctrl;

  localparam int SOURCES = 16;
  localparam int PB      = 3;
  localparam int SB      = 5;

  typedef logic [SOURCES-1:0][PB-1:0] prio_t;

  typedef struct {
    logic              chk;
    logic              rst;
    logic [SOURCES-1:0] pend;
    logic [SOURCES-1:0] en;
    prio_t             prio;
    logic [PB-1:0]     thr;
    logic              claim;
    logic              cmp;
    logic [SB-1:0]     cmp_id;
    logic              e_irq;
    logic [SB-1:0]     e_id;
    logic [SOURCES-1:0] e_claim;
    logic [SOURCES-1:0] e_cmp;
  } vec_t;

  typedef struct {
    int                idx;
    logic              irq;
    logic [SB-1:0]     id;
    logic [SOURCES-1:0] clm;
    logic [SOURCES-1:0] cmp;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [SOURCES-1:0] src_pending;
  logic [SOURCES-1:0] src_enable;
  prio_t              src_priority;
  logic [PB-1:0]      threshold;
  logic               irq;
  logic               claim;
  logic [SB-1:0]      claim_id;
  logic [SOURCES-1:0] claim_pulse;
  logic               complete;
  logic [SB-1:0]      complete_id;
  logic [SOURCES-1:0] complete_pulse;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  plic_target_claim_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .src_pending_i  (src_pending),
    .src_enable_i   (src_enable),
    .src_priority_i (src_priority),
    .threshold_i    (threshold),
    .irq_o          (irq),
    .claim_i        (claim),
    .claim_id_o     (claim_id),
    .claim_o        (claim_pulse),
    .complete_i     (complete),
    .complete_id_i  (complete_id),
    .complete_o     (complete_pulse)
  );

  function automatic logic [SOURCES-1:0] b(input int id);
    return SOURCES'(1) << (id - 1);
  endfunction

  function automatic prio_t p(input int id, input int v);
    prio_t r = '0;
    r[id-1] = PB'(v);
    return r;
  endfunction

  function automatic vec_t mk(input logic chk, input logic r, input logic [SOURCES-1:0] pd,
                              input logic [SOURCES-1:0] e, input prio_t pr, input int th,
                              input logic cl, input logic cp, input int cid,
                              input logic ei, input int eid, input logic [SOURCES-1:0] ec,
                              input logic [SOURCES-1:0] ecp);
    vec_t v;
    v.chk = chk; v.rst = r; v.pend = pd; v.en = e; v.prio = pr; v.thr = PB'(th);
    v.claim = cl; v.cmp = cp; v.cmp_id = SB'(cid);
    v.e_irq = ei; v.e_id = SB'(eid); v.e_claim = ec; v.e_cmp = ecp;
    return v;
  endfunction

  // Outputs for the cycle a vector is applied are sampled at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (irq !== e.irq) begin
        n_err++;
        $display("FAIL v%0d irq: got %0b want %0b", e.idx, irq, e.irq);
      end
      n_cmp++;
      if (claim_id !== e.id) begin
        n_err++;
        $display("FAIL v%0d claim_id: got %0d want %0d", e.idx, claim_id, e.id);
      end
      n_cmp++;
      if (claim_pulse !== e.clm) begin
        n_err++;
        $display("FAIL v%0d claim_o: got %h want %h", e.idx, claim_pulse, e.clm);
      end
      n_cmp++;
      if (complete_pulse !== e.cmp) begin
        n_err++;
        $display("FAIL v%0d complete_o: got %h want %h", e.idx, complete_pulse, e.cmp);
      end
    end
  end

  initial begin
    logic [SOURCES-1:0] z;
    z = '0;

    // Reset and idle
    vecs.push_back(mk(0, 1, z, z, '0, 0, 0, 0, 0, 0, 0, z, z));
    vecs.push_back(mk(1, 1, z, z, '0, 0, 0, 0, 0, 0, 0, z, z));
    vecs.push_back(mk(1, 0, z, z, '0, 0, 0, 0, 0, 0, 0, z, z));
    // ID 3, prio 5, threshold 2; one-cycle latency; threshold acts same cycle
    vecs.push_back(mk(1, 0, b(3), b(3), p(3,5), 2, 0, 0, 0, 0, 0, z, z));
    vecs.push_back(mk(1, 0, b(3), b(3), p(3,5), 2, 0, 0, 0, 1, 3, z, z));
    vecs.push_back(mk(1, 0, b(3), b(3), p(3,5), 5, 0, 0, 0, 0, 0, z, z));
    vecs.push_back(mk(1, 0, b(3), b(3), p(3,5), 4, 0, 0, 0, 1, 3, z, z));
    // Tie between 4 and 9 goes to 4; disabling 4 exposes 9 a cycle later
    vecs.push_back(mk(1, 0, b(4)|b(9), b(4)|b(9), p(4,6)|p(9,6), 2, 0, 0, 0, 1, 3, z, z));
    vecs.push_back(mk(1, 0, b(4)|b(9), b(4)|b(9), p(4,6)|p(9,6), 2, 0, 0, 0, 1, 4, z, z));
    vecs.push_back(mk(1, 0, b(4)|b(9), b(9),      p(4,6)|p(9,6), 2, 0, 0, 0, 1, 4, z, z));
    vecs.push_back(mk(1, 0, b(4)|b(9), b(9),      p(4,6)|p(9,6), 2, 0, 0, 0, 1, 9, z, z));
    // Higher priority on a lower ID; threshold equal to priority blocks
    vecs.push_back(mk(1, 0, b(2)|b(9), b(2)|b(9), p(2,7)|p(9,6), 2, 0, 0, 0, 1, 9, z, z));
    vecs.push_back(mk(1, 0, b(2)|b(9), b(2)|b(9), p(2,7)|p(9,6), 2, 0, 0, 0, 1, 2, z, z));
    vecs.push_back(mk(1, 0, b(2)|b(9), b(2)|b(9), p(2,7)|p(9,6), 7, 0, 0, 0, 0, 0, z, z));
    // Priority 0 never interrupts, even at threshold 0
    vecs.push_back(mk(1, 0, b(5), b(5), '0, 0, 0, 0, 0, 1, 2, z, z));
    vecs.push_back(mk(1, 0, b(5), b(5), '0, 0, 0, 0, 0, 0, 0, z, z));
    // Completes: 12 valid, 0 and 17 ignored, 16 valid
    vecs.push_back(mk(1, 0, z, z, '0, 0, 0, 1, 12, 0, 0, z, z));
    vecs.push_back(mk(1, 0, z, z, '0, 0, 0, 1, 0,  0, 0, z, 16'h0800));
    vecs.push_back(mk(1, 0, z, z, '0, 0, 0, 1, 17, 0, 0, z, z));
    vecs.push_back(mk(1, 0, z, z, '0, 0, 0, 1, 16, 0, 0, z, z));
    vecs.push_back(mk(1, 0, z, z, '0, 0, 0, 0, 0,  0, 0, z, 16'h8000));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; src_pending = vecs[i].pend; src_enable = vecs[i].en;
      src_priority = vecs[i].prio; threshold = vecs[i].thr; claim = vecs[i].claim;
      complete = vecs[i].cmp; complete_id = vecs[i].cmp_id;
      if (vecs[i].chk) begin
        sb.push_back('{i, vecs[i].e_irq, vecs[i].e_id, vecs[i].e_claim, vecs[i].e_cmp});
      end
    end

    // Hand-written multi-cycle sequences: claim/hold, ignored claims,
    // claim+complete together, reset in the middle of a hold.
    vecs.delete();
    vecs.push_back(mk(1, 0, b(7)|b(10), b(7)|b(10), p(7,4)|p(10,2), 1, 0, 0, 0, 0, 0,  z, z));
    vecs.push_back(mk(1, 0, b(7)|b(10), b(7)|b(10), p(7,4)|p(10,2), 1, 1, 0, 0, 1, 7,  z, z));
    vecs.push_back(mk(1, 0, b(7)|b(10), b(7)|b(10), p(7,4)|p(10,2), 1, 1, 0, 0, 0, 0,  16'h0040, z));
    vecs.push_back(mk(1, 0, b(10), b(7)|b(10), p(7,4)|p(10,2), 1, 0, 0, 0, 0, 0,  z, z));
    vecs.push_back(mk(1, 0, b(10), b(7)|b(10), p(7,4)|p(10,2), 1, 0, 0, 0, 1, 10, z, z));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 3, 1, 0, 0, 0, 0,  z, z));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 3, 0, 0, 0, 0, 0,  z, z));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 1, 1, 1, 3, 1, 10, z, z));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 1, 0, 0, 0, 0, 0,  16'h0200, 16'h0004));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 1, 0, 0, 0, 0, 0,  z, z));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 1, 1, 0, 0, 1, 10, z, z));
    vecs.push_back(mk(1, 1, b(10), b(10), p(10,2), 1, 0, 1, 5, 0, 0,  16'h0200, z));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 1, 0, 0, 0, 0, 0,  z, z));
    vecs.push_back(mk(1, 0, b(10), b(10), p(10,2), 1, 0, 0, 0, 1, 10, z, z));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; src_pending = vecs[i].pend; src_enable = vecs[i].en;
      src_priority = vecs[i].prio; threshold = vecs[i].thr; claim = vecs[i].claim;
      complete = vecs[i].cmp; complete_id = vecs[i].cmp_id;
      if (vecs[i].chk) begin
        sb.push_back('{100 + i, vecs[i].e_irq, vecs[i].e_id, vecs[i].e_claim, vecs[i].e_cmp});
      end
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(posedge clk);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
